// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the CPU request/completion port and the APB-style slave bus seen
// by apb_master_bridge.
//   master modport : the bridge side (consumes CPU requests and slave
//                    responses, drives completions and the APB bus)
//   slave  modport : the environment side (CPU + peripheral)
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   request from the core
//   cpu_ready/cpu_done/cpu_err/cpu_rdata completion back to the core
//   apb_req/apb_psel/apb_rw/apb_addr/apb_enab/apb_wdata  bus to slave
//   apb_rdata/apb_ack                   slave response
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

interface apb_master_bridge_if;
  logic                       cpu_req;
  logic                       cpu_we;
  logic [`ADDR_WIDTH-1:0]     cpu_addr;
  logic [`APB_DATA_WIDTH-1:0] cpu_wdata;
  logic                       cpu_ready;
  logic                       cpu_done;
  logic                       cpu_err;
  logic [`APB_DATA_WIDTH-1:0] cpu_rdata;

  logic                       apb_req;
  logic                       apb_psel;
  logic                       apb_rw;
  logic [`ADDR_WIDTH-1:0]     apb_addr;
  logic                       apb_enab;
  logic [`APB_DATA_WIDTH-1:0] apb_wdata;
  logic [`APB_DATA_WIDTH-1:0] apb_rdata;
  logic                       apb_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, apb_rdata, apb_ack,
    output cpu_ready, cpu_done, cpu_err, cpu_rdata,
           apb_req, apb_psel, apb_rw, apb_addr, apb_enab, apb_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, apb_rdata, apb_ack,
    input  cpu_ready, cpu_done, cpu_err, cpu_rdata,
           apb_req, apb_psel, apb_rw, apb_addr, apb_enab, apb_wdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Single-outstanding bridge from the core's peripheral request port to the
// APB-style slave bus. One request is accepted in IDLE, driven through a
// one-cycle SETUP phase and an ACCESS phase that lasts until apb_ack or until
// TIMEOUT ACCESS cycles have elapsed (abort with cpu_err).
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    apb_master_bridge_if.master (CPU port + APB bus)
// Parameters:
//   TIMEOUT  ACCESS cycles before abort, 1..255
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request; completion pulse shows here
// SETUP  | psel high, enab low, one cycle
// ACCESS | psel+enab high, waiting for ack or timeout
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  apb_master_bridge_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                     state_q;
  logic [7:0]                 cnt_q;
  logic                       ready_q;
  logic                       done_q;
  logic                       err_q;
  logic [`APB_DATA_WIDTH-1:0] rdata_q;
  logic                       req_q;
  logic                       psel_q;
  logic                       enab_q;
  logic                       rw_q;
  logic [`ADDR_WIDTH-1:0]     addr_q;
  logic [`APB_DATA_WIDTH-1:0] wdata_q;

  logic [7:0]                 cnt_d;
  logic                       tmo_hit;

  assign cnt_d   = cnt_q + 8'd1;
  assign tmo_hit = (cnt_q == 8'(TIMEOUT - 1));

  // All outputs come straight from registers; the whole FSM lives in one
  // sequential block so each output is set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      psel_q  <= 1'b0;
      enab_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            rw_q    <= bus.cpu_we;
            wdata_q <= bus.cpu_wdata;
            ready_q <= 1'b0;
            req_q   <= 1'b1;
            psel_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q   <= 8'd0;
          enab_q  <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (bus.apb_ack || tmo_hit) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            psel_q  <= 1'b0;
            enab_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= ~bus.apb_ack;
            // Writes leave the read-data register alone; an aborted read
            // returns zero rather than whatever the dead slave drives.
            if (!rw_q) begin
              rdata_q <= bus.apb_ack ? bus.apb_rdata : '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          req_q   <= 1'b0;
          psel_q  <= 1'b0;
          enab_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_done  = done_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.apb_req   = req_q;
  assign bus.apb_psel  = psel_q;
  assign bus.apb_enab  = enab_q;
  assign bus.apb_rw    = rw_q;
  assign bus.apb_addr  = addr_q;
  assign bus.apb_wdata = wdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module tb_apb_master_bridge;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  apb_master_bridge_if bif ();

  apb_master_bridge #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_issued = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  // Completion monitor: every cpu_done pops one expected response.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.cpu_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got cpu_done=1 expected no completion at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_err", {31'd0, bif.cpu_err}, {31'd0, e.err});
          check("done_rdata", bif.cpu_rdata, e.rdata);
        end
      end else begin
        check("err_without_done", {31'd0, bif.cpu_err}, 32'd0);
      end
    end
  end

  // Starts at a negedge where the bridge should be ready; returns at the
  // negedge of the cpu_done cycle so the caller may issue back-to-back.
  // nwait >= TMO means the slave never acknowledges.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int nwait, input logic [31:0] rdata_s, input logic stale);
    exp_t e;
    int   enab_cnt;
    int   exp_enab;
    check("ready_before_req", {31'd0, bif.cpu_ready}, 32'd1);
    bif.cpu_req   = 1'b1;
    bif.cpu_we    = we;
    bif.cpu_addr  = addr;
    bif.cpu_wdata = wdata;
    e.err = (nwait >= TMO);
    if (we)              e.rdata = last_rdata;
    else if (nwait >= TMO) e.rdata = 32'h0;
    else                 e.rdata = rdata_s;
    last_rdata = e.rdata;
    exp_q.push_back(e);
    n_issued++;
    exp_enab = (nwait >= TMO) ? TMO : nwait + 1;

    @(negedge clk);  // SETUP
    bif.cpu_req = 1'b0;
    check("setup_psel", {31'd0, bif.apb_psel}, 32'd1);
    check("setup_enab", {31'd0, bif.apb_enab}, 32'd0);
    check("setup_req", {31'd0, bif.apb_req}, 32'd1);
    check("setup_ready", {31'd0, bif.cpu_ready}, 32'd0);
    check("setup_addr", bif.apb_addr, addr);
    check("setup_rw", {31'd0, bif.apb_rw}, {31'd0, we});
    check("setup_wdata", bif.apb_wdata, wdata);
    if (stale) begin
      bif.apb_ack   = 1'b1;
      bif.apb_rdata = 32'hDEAD_BEEF;
    end

    enab_cnt = 0;
    for (int i = 0; i < TMO + 2; i++) begin
      @(negedge clk);
      if (!bif.apb_enab) break;
      enab_cnt++;
      check("access_addr", bif.apb_addr, addr);
      check("access_wdata", bif.apb_wdata, wdata);
      check("access_psel", {31'd0, bif.apb_psel}, 32'd1);
      if (stale) begin
        bif.cpu_req  = (i != nwait) && i[0];
        bif.cpu_addr = 32'h70 + i;
        bif.cpu_we   = ~we;
      end
      bif.apb_ack   = (i == nwait);
      bif.apb_rdata = (i == nwait) ? rdata_s : (32'hBAD0_0000 | i);
    end
    // Now at the negedge of the completion cycle.
    bif.apb_ack  = 1'b0;
    bif.cpu_req  = 1'b0;
    check("enab_cycles", enab_cnt, exp_enab);
    check("done_pulse", {31'd0, bif.cpu_done}, 32'd1);
    check("done_ready", {31'd0, bif.cpu_ready}, 32'd1);
    check("done_psel", {31'd0, bif.apb_psel}, 32'd0);
  endtask

  initial begin
    bif.cpu_req   = 1'b0;
    bif.cpu_we    = 1'b0;
    bif.cpu_addr  = '0;
    bif.cpu_wdata = '0;
    bif.apb_ack   = 1'b0;
    bif.apb_rdata = '0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, bif.cpu_ready}, 32'd1);
    check("rst_done", {31'd0, bif.cpu_done}, 32'd0);
    check("rst_rdata", bif.cpu_rdata, 32'd0);
    check("rst_apb", {bif.apb_req, bif.apb_psel, bif.apb_enab, bif.apb_rw}, 32'd0);
    check("rst_apb_addr", bif.apb_addr, 32'd0);
    check("rst_apb_wdata", bif.apb_wdata, 32'd0);

    // Write, immediate ack: done 3 cycles after acceptance.
    xfer(1'b1, 32'h3, 32'hA5A5_0001, 0, 32'h0, 1'b0);
    @(negedge clk);
    // Read with four wait states.
    xfer(1'b0, 32'h5, 32'h0, 4, 32'h1234_5678, 1'b0);
    @(negedge clk);
    // Timeout, then a normal read.
    xfer(1'b0, 32'h7, 32'h0, TMO, 32'h0, 1'b0);
    @(negedge clk);
    check("idle_after_tmo", {31'd0, bif.apb_psel}, 32'd0);
    xfer(1'b0, 32'h2, 32'h0, 1, 32'hCAFE_0002, 1'b0);
    @(negedge clk);
    // Back-to-back: write then read issued in the write's done cycle.
    xfer(1'b1, 32'hA, 32'h1111_2222, 0, 32'h0, 1'b0);
    xfer(1'b0, 32'h1, 32'h0, 2, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    // Busy/stale inputs.
    xfer(1'b0, 32'hC, 32'h0, 3, 32'h5555_AAAA, 1'b1);
    @(negedge clk);

    // Reset in the middle of ACCESS: no completion expected.
    bif.cpu_req  = 1'b1;
    bif.cpu_we   = 1'b1;
    bif.cpu_addr = 32'h9;
    bif.cpu_wdata = 32'h9999_0000;
    @(negedge clk);
    bif.cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_enab", {31'd0, bif.apb_enab}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rdata = 32'h0;
    check("midrst_apb", {bif.apb_req, bif.apb_psel, bif.apb_enab, bif.apb_rw}, 32'd0);
    check("midrst_addr", bif.apb_addr, 32'd0);
    check("midrst_wdata", bif.apb_wdata, 32'd0);
    check("midrst_ready", {31'd0, bif.cpu_ready}, 32'd1);
    check("midrst_done", {31'd0, bif.cpu_done}, 32'd0);
    @(negedge clk);
    check("post_rst_done", {31'd0, bif.cpu_done}, 32'd0);
    xfer(1'b0, 32'hE, 32'h0, 0, 32'h7777_0000, 1'b0);

    repeat (4) @(negedge clk);
    check("pending_expected", exp_q.size(), 32'd0);
    check("done_count", n_done, n_issued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion of bench");
    $fatal(1);
  end

endmodule
